// File: rtl/bus_arb2_pkg.sv
// Shared state encodings and constants for the two-master bus arbiter.
package bus_arb2_pkg;

    localparam logic [1:0]  ST_IDLE   = 2'd0;
    localparam logic [1:0]  ST_ACCESS = 2'd1;
    localparam logic [1:0]  ST_RESP   = 2'd2;

    // Read data returned to the owner when the slave never acknowledges.
    localparam logic [31:0] RDATA_TIMEOUT = 32'h0000_0000;

endpackage

// File: rtl/MUX2T1_32.sv
// 32-bit 2:1 multiplexer used on the arbiter request path.
module MUX2T1_32 (
    input  logic [31:0] i_d0,
    input  logic [31:0] i_d1,
    input  logic        i_sel,
    output logic [31:0] o_y
);

    assign o_y = i_sel ? i_d1 : i_d0;

endmodule

// File: rtl/bus_arb2.sv
// Round-robin arbiter granting one of two masters a single-slave bus,
// with a per-transaction ack timeout.
module bus_arb2
    import bus_arb2_pkg::*;
#(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        we0,
    input  logic [31:0] addr0,
    input  logic [31:0] wdata0,
    input  logic        req1,
    input  logic        we1,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata1,
    output logic        ack0,
    output logic        ack1,
    output logic        err0,
    output logic        err1,
    output logic [31:0] rdata,
    output logic        sel,
    output logic        busy,
    output logic        bus_stb,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    localparam logic [3:0] TO_LAST = 4'(TIMEOUT - 1);

    logic [1:0]  r_state;
    logic [3:0]  r_cnt;
    logic        r_last;
    logic        r_sel;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic        r_ack0, r_ack1, r_err0, r_err1;

    logic        w_any;
    logic        w_win;
    logic        w_we;
    logic [31:0] w_addr;
    logic [31:0] w_wdata;

    // On a tie the master that did not own the bus last time wins.
    assign w_any = req0 | req1;
    assign w_win = (req0 & req1) ? ~r_last : req1;
    assign w_we  = w_win ? we1 : we0;

    MUX2T1_32 u_mux_addr  (.i_d0(addr0),  .i_d1(addr1),  .i_sel(w_win), .o_y(w_addr));
    MUX2T1_32 u_mux_wdata (.i_d0(wdata0), .i_d1(wdata1), .i_sel(w_win), .o_y(w_wdata));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_last  <= 1'b1;
            r_sel   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_rdata <= 32'd0;
            r_ack0  <= 1'b0;
            r_ack1  <= 1'b0;
            r_err0  <= 1'b0;
            r_err1  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_sel   <= w_win;
                        r_we    <= w_we;
                        r_addr  <= w_addr;
                        r_wdata <= w_wdata;
                        r_cnt   <= 4'd0;
                        r_state <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    // An ack arriving on the timeout edge takes priority over err.
                    if (bus_ack) begin
                        r_rdata <= bus_rdata;
                        r_ack0  <= ~r_sel;
                        r_ack1  <= r_sel;
                        r_state <= ST_RESP;
                    end else if (r_cnt == TO_LAST) begin
                        r_rdata <= RDATA_TIMEOUT;
                        r_err0  <= ~r_sel;
                        r_err1  <= r_sel;
                        r_state <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                ST_RESP: begin
                    r_last  <= r_sel;
                    r_ack0  <= 1'b0;
                    r_ack1  <= 1'b0;
                    r_err0  <= 1'b0;
                    r_err1  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Strobe is decoded from state so an async reset drops it immediately.
    assign bus_stb   = (r_state == ST_ACCESS);
    assign busy      = (r_state == ST_ACCESS) || (r_state == ST_RESP);
    assign bus_we    = r_we;
    assign bus_addr  = r_addr;
    assign bus_wdata = r_wdata;
    assign sel       = r_sel;
    assign rdata     = r_rdata;
    assign ack0      = r_ack0;
    assign ack1      = r_ack1;
    assign err0      = r_err0;
    assign err1      = r_err1;

endmodule

// File: tb/tb_bus_arb2.sv
// Directed self-checking bench for bus_arb2 (TIMEOUT=4).
module tb_bus_arb2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, we0, req1, we1;
    logic [31:0] addr0, wdata0, addr1, wdata1;
    logic        ack0, ack1, err0, err1;
    logic [31:0] rdata;
    logic        sel, busy, bus_stb, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    bus_arb2 #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1),
        .rdata(rdata), .sel(sel), .busy(busy),
        .bus_stb(bus_stb), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] exp_addr [3];
    logic        exp_sel  [3];

    initial begin
        rst = 1'b1; req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
        req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0; bus_ack = 0; bus_rdata = 0;
        tick(); tick();
        chk("rst_stb", {31'd0, bus_stb}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_sel", {31'd0, sel}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_addr", bus_addr, 32'd0);
        chk("rst_ackerr", {28'd0, ack0, ack1, err0, err1}, 32'd0);
        rst = 1'b0;

        // single read
        req0 = 1; addr0 = 32'h0000_0040;
        tick();
        chk("rd_stb", {31'd0, bus_stb}, 32'd1);
        chk("rd_addr", bus_addr, 32'h40);
        chk("rd_we", {31'd0, bus_we}, 32'd0);
        bus_ack = 1; bus_rdata = 32'hCAFE_0001;
        tick();
        chk("rd_ack0", {30'd0, ack0, ack1}, 32'b10);
        chk("rd_rdata", rdata, 32'hCAFE_0001);
        chk("rd_stb_off", {31'd0, bus_stb}, 32'd0);
        req0 = 0; bus_ack = 0;
        tick();
        chk("rd_ack_clr", {31'd0, ack0}, 32'd0);
        chk("rd_idle", {31'd0, busy}, 32'd0);

        // tie after reset: 0,1,0 with both requests held
        rst = 1; #1; rst = 0;
        req0 = 1; req1 = 1; addr0 = 32'h100; addr1 = 32'h200; bus_ack = 1; bus_rdata = 32'h5;
        exp_sel[0] = 0; exp_sel[1] = 1; exp_sel[2] = 0;
        exp_addr[0] = 32'h100; exp_addr[1] = 32'h200; exp_addr[2] = 32'h100;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("rr_sel%0d", i), {31'd0, sel}, {31'd0, exp_sel[i]});
            chk($sformatf("rr_addr%0d", i), bus_addr, exp_addr[i]);
            if (i == 0) addr1 = 32'h2FF;
            tick();
            chk($sformatf("rr_ack%0d", i), {30'd0, ack0, ack1},
                exp_sel[i] ? 32'b01 : 32'b10);
            chk($sformatf("rr_hold%0d", i), bus_addr, exp_addr[i]);
            if (i == 0) addr1 = 32'h200;
            tick();
        end
        req0 = 0; req1 = 0; bus_ack = 0;
        tick();

        // write with 3 wait states; ack lands on the timeout edge
        req1 = 1; we1 = 1; addr1 = 32'h300; wdata1 = 32'hDEAD_BEEF; bus_rdata = 32'h77;
        tick();
        chk("ws_we", {31'd0, bus_we}, 32'd1);
        chk("ws_wdata", bus_wdata, 32'hDEAD_BEEF);
        chk("ws_sel", {31'd0, sel}, 32'd1);
        addr0 = 32'h999; req0 = 1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("ws_stb%0d", i), {31'd0, bus_stb}, 32'd1);
            chk($sformatf("ws_addr%0d", i), bus_addr, 32'h300);
            chk($sformatf("ws_noack%0d", i), {31'd0, ack1}, 32'd0);
            if (i == 3) bus_ack = 1;
            tick();
        end
        chk("ws_ack1", {28'd0, ack0, ack1, err0, err1}, 32'b0100);
        chk("ws_rdata", rdata, 32'h77);
        req0 = 0; req1 = 0; we1 = 0; bus_ack = 0;
        tick();
        chk("ws_ack_clr", {31'd0, ack1}, 32'd0);

        // timeout on master 0
        req0 = 1; addr0 = 32'h400;
        tick();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("to_stb%0d", i), {31'd0, bus_stb}, 32'd1);
            tick();
        end
        chk("to_err0", {28'd0, ack0, ack1, err0, err1}, 32'b0010);
        chk("to_rdata", rdata, 32'd0);
        req0 = 0;
        tick();
        chk("to_err_clr", {31'd0, err0}, 32'd0);
        req0 = 1; addr0 = 32'h404; bus_ack = 1; bus_rdata = 32'h1234;
        tick();
        chk("to_next_addr", bus_addr, 32'h404);
        tick();
        chk("to_next_ack", {28'd0, ack0, ack1, err0, err1}, 32'b1000);
        chk("to_next_rdata", rdata, 32'h1234);
        req0 = 0; bus_ack = 0;
        tick();

        // reset in the middle of an access (last owner is now 0)
        req1 = 1; addr1 = 32'h500;
        tick();
        chk("ra_stb", {31'd0, bus_stb}, 32'd1);
        #2 rst = 1;
        #1;
        chk("ra_stb_drop", {31'd0, bus_stb}, 32'd0);
        bus_ack = 1;
        tick();
        chk("ra_noackerr", {28'd0, ack0, ack1, err0, err1}, 32'd0);
        rst = 0; bus_ack = 0; req0 = 1; req1 = 1; addr0 = 32'h600;
        tick();
        chk("ra_tie_sel", {31'd0, sel}, 32'd0);
        chk("ra_tie_addr", bus_addr, 32'h600);
        req0 = 0; req1 = 0;

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
